// File: rtl/iob2axi_wr_burst_pkg.sv
// Shared AXI constants for the native-to-AXI4 write burst engine.
package iob2axi_wr_burst_pkg;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam int         AXI4_LEN_W    = 8;
  localparam int         BOUNDARY_4K_W = 12;
endpackage

// File: rtl/iob_fifo_sync.sv
// Synchronous FIFO with a first-word-fall-through output register and level count.
module iob_fifo_sync #(
  parameter int W_DATA = 36,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [W_DATA-1:0] w_data,
  output logic              full,
  input  logic              r_en,
  output logic [W_DATA-1:0] r_data,
  output logic              empty,
  output logic [ADDR_W:0]   level
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  logic [W_DATA-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   mem_cnt;
  logic              out_vld, push, pop, rd;

  assign full  = (mem_cnt == DEPTH_C);
  assign empty = ~out_vld;
  assign rd    = r_en & out_vld;
  assign push  = w_en & ~full;
  // Refill the output register whenever it is empty or being consumed.
  assign pop   = (mem_cnt != '0) & (~out_vld | rd);
  assign level = mem_cnt + {{ADDR_W{1'b0}}, out_vld};

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= w_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      mem_cnt <= '0;
      out_vld <= 1'b0;
      r_data  <= '0;
    end else begin
      if (push) wptr <= wptr + ADDR_W'(1);
      if (pop) begin
        r_data <= mem[rptr];
        rptr   <= rptr + ADDR_W'(1);
      end
      if (pop)     out_vld <= 1'b1;
      else if (rd) out_vld <= 1'b0;
      case ({push, pop})
        2'b10:   mem_cnt <= mem_cnt + (ADDR_W+1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (ADDR_W+1)'(1);
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end
endmodule

// File: rtl/iob2axi_wr_burst.sv
// Bounded native-to-AXI4 write burst engine: buffers words, emits INCR bursts
// sized by remaining length, MAX_BURST and the 4 KB page, one burst in flight.
module iob2axi_wr_burst
  import iob2axi_wr_burst_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 16,
  parameter int AXI_LEN_W   = AXI4_LEN_W,
  parameter int MAX_BURST   = 16,
  parameter int FIFO_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [LEN_W-1:0]     length,
  output logic                 ready,
  output logic                 done,
  output logic                 error,
  input  logic                 s_valid,
  input  logic [DATA_W-1:0]    s_wdata,
  input  logic [DATA_W/8-1:0]  s_wstrb,
  output logic                 s_ready,
  output logic [ADDR_W-1:0]    m_axi_awaddr,
  output logic [AXI_LEN_W-1:0] m_axi_awlen,
  output logic [2:0]           m_axi_awsize,
  output logic [1:0]           m_axi_awburst,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  output logic [DATA_W-1:0]    m_axi_wdata,
  output logic [DATA_W/8-1:0]  m_axi_wstrb,
  output logic                 m_axi_wlast,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  input  logic [1:0]           m_axi_bresp,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready
);
  localparam int STRB_W = DATA_W / 8;
  localparam int BSH    = $clog2(STRB_W);
  localparam int CW     = (LEN_W + 1 > BOUNDARY_4K_W + 1) ? LEN_W + 1 : BOUNDARY_4K_W + 1;
  localparam int FW     = DATA_W + STRB_W;
  localparam logic [BOUNDARY_4K_W:0] PAGE_BYTES = {1'b1, {BOUNDARY_4K_W{1'b0}}};
  localparam logic [ADDR_W-1:0]      ADDR_MASK  = ~ADDR_W'(STRB_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_DATA, S_RESP} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0]        addr_cur;
  logic [LEN_W-1:0]         length_reg, remaining, accepted_cnt;
  logic [LEN_W:0]           blen, beat_cnt;
  logic [BOUNDARY_4K_W:0]   bytes_to_4k;
  logic [CW-1:0]            words_to_4k, blen_c;
  logic [FIFO_ADDR_W:0]     fifo_level;
  logic [FW-1:0]            fifo_dout;
  logic                     fifo_full, fifo_empty, fifo_wr, w_fire, last_beat, burst_ok, last_burst;

  assign ready         = (state == S_IDLE);
  assign s_ready       = (state != S_IDLE) & ~fifo_full & (accepted_cnt < length_reg);
  assign fifo_wr       = s_valid & s_ready;
  assign m_axi_wvalid  = (state == S_DATA) & ~fifo_empty;
  assign w_fire        = m_axi_wvalid & m_axi_wready;
  assign last_beat     = (beat_cnt == blen - (LEN_W+1)'(1));
  assign m_axi_wlast   = (state == S_DATA) & last_beat;
  assign m_axi_bready  = (state == S_RESP);
  assign m_axi_awsize  = 3'(BSH);
  assign m_axi_awburst = BURST_INCR;
  assign {m_axi_wdata, m_axi_wstrb} = fifo_dout;
  assign last_burst    = (remaining == LEN_W'(blen));

  // Burst length = min(remaining, MAX_BURST, words left in the 4 KB page),
  // evaluated wide enough that none of the terms truncates.
  assign bytes_to_4k = PAGE_BYTES - {1'b0, addr_cur[BOUNDARY_4K_W-1:0]};
  assign words_to_4k = CW'(bytes_to_4k >> BSH);
  always_comb begin
    blen_c = CW'(remaining);
    if (CW'(MAX_BURST) < blen_c) blen_c = CW'(MAX_BURST);
    if (words_to_4k < blen_c)    blen_c = words_to_4k;
  end
  assign burst_ok = (CW'(fifo_level) >= blen_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (run && length != '0) state_nxt = S_CALC;
      S_CALC: if (burst_ok) state_nxt = S_ADDR;
      S_ADDR: if (m_axi_awready) state_nxt = S_DATA;
      S_DATA: if (w_fire && last_beat) state_nxt = S_RESP;
      S_RESP: if (m_axi_bvalid) state_nxt = last_burst ? S_IDLE : S_CALC;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cur      <= '0;
      length_reg    <= '0;
      remaining     <= '0;
      accepted_cnt  <= '0;
      blen          <= '0;
      beat_cnt      <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      m_axi_awvalid <= 1'b0;
      error         <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fifo_wr) accepted_cnt <= accepted_cnt + LEN_W'(1);
      case (state)
        S_IDLE: if (run) begin
          addr_cur     <= addr & ADDR_MASK;
          length_reg   <= length;
          remaining    <= length;
          accepted_cnt <= '0;
          error        <= 1'b0;
          if (length == '0) done <= 1'b1;
        end
        S_CALC: if (burst_ok) begin
          m_axi_awaddr  <= addr_cur;
          m_axi_awlen   <= AXI_LEN_W'(blen_c - CW'(1));
          blen          <= (LEN_W+1)'(blen_c);
          m_axi_awvalid <= 1'b1;
        end
        S_ADDR: if (m_axi_awready) begin
          m_axi_awvalid <= 1'b0;
          beat_cnt      <= '0;
        end
        S_DATA: if (w_fire) beat_cnt <= beat_cnt + (LEN_W+1)'(1);
        S_RESP: if (m_axi_bvalid) begin
          if (m_axi_bresp != RESP_OKAY) error <= 1'b1;
          addr_cur  <= addr_cur + (ADDR_W'(blen) << BSH);
          remaining <= remaining - LEN_W'(blen);
          if (last_burst) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  iob_fifo_sync #(.W_DATA(FW), .ADDR_W(FIFO_ADDR_W)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .w_en   (fifo_wr),
    .w_data ({s_wdata, s_wstrb}),
    .full   (fifo_full),
    .r_en   (w_fire),
    .r_data (fifo_dout),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );
endmodule

// File: tb/tb_iob2axi_wr_burst.sv
// Directed bench for iob2axi_wr_burst: native source + AXI slave agent, checks in one sequence.
module tb_iob2axi_wr_burst;
  logic        clk = 1'b0, rst = 1'b1, run = 1'b0;
  logic [31:0] addr = '0;
  logic [15:0] length = '0;
  logic        ready, done, error, s_ready;
  logic        s_valid = 1'b0;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic [31:0] m_axi_awaddr, m_axi_wdata;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst, m_axi_bresp = 2'b00;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wlast, m_axi_wvalid, m_axi_bready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;

  iob2axi_wr_burst dut (
    .clk(clk), .rst(rst), .run(run), .addr(addr), .length(length),
    .ready(ready), .done(done), .error(error),
    .s_valid(s_valid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Agent state and logs
  logic [35:0] src_q[$];
  logic [31:0] aw_a[$];
  logic [7:0]  aw_l[$];
  logic [35:0] w_d[$];
  bit          w_l[$];
  bit          err_hist[$];
  int  aw_delay = 0, aw_cnt = 0, err_burst = 99, b_idx = 0, done_cnt = 0;
  int  aw_unstable = 0, order_err = 0, wlast_cnt = 0;
  bit  wr_toggle = 0, tog = 0, b_pend = 0, b_prev = 0, aw_held = 0, aw_ever = 0;
  logic [31:0] hold_a;
  logic [7:0]  hold_l;

  initial forever begin
    @(negedge clk);
    s_valid = (src_q.size() > 0);
    if (s_valid) {s_wdata, s_wstrb} = src_q[0];
    m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_delay);
    tog = ~tog;
    m_axi_wready = wr_toggle ? tog : 1'b1;
    m_axi_bvalid = b_pend;
    m_axi_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
    #3;
    if (b_prev) err_hist.push_back(error);
    b_prev = 0;
    if (s_valid && s_ready) void'(src_q.pop_front());
    if (m_axi_awvalid) begin
      aw_ever = 1;
      if (aw_held && (m_axi_awaddr !== hold_a || m_axi_awlen !== hold_l)) aw_unstable++;
      if (m_axi_awready) begin
        aw_a.push_back(m_axi_awaddr); aw_l.push_back(m_axi_awlen);
        aw_cnt = 0; aw_held = 0;
      end else begin
        aw_cnt++; aw_held = 1; hold_a = m_axi_awaddr; hold_l = m_axi_awlen;
      end
    end
    if (m_axi_wvalid && m_axi_wready) begin
      if (aw_a.size() <= wlast_cnt) order_err++;
      w_d.push_back({m_axi_wdata, m_axi_wstrb});
      w_l.push_back(m_axi_wlast);
      if (m_axi_wlast) begin wlast_cnt++; b_pend = 1; end
    end
    if (m_axi_bvalid && m_axi_bready) begin b_pend = 0; b_idx++; b_prev = 1; end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clear_logs();
    src_q.delete(); aw_a.delete(); aw_l.delete(); w_d.delete(); w_l.delete(); err_hist.delete();
    aw_cnt = 0; b_idx = 0; done_cnt = 0; aw_unstable = 0; order_err = 0; wlast_cnt = 0;
    b_pend = 0; b_prev = 0; aw_held = 0; aw_ever = 0;
  endtask

  task automatic start_run(input logic [31:0] a, input logic [15:0] l);
    addr = a; length = l; run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    for (int i = 0; i < 3000 && done_cnt < target; i++) tick();
    chk(tag, done_cnt, target);
  endtask

  task automatic chk_aw(input string tag, input int idx, input logic [31:0] ea, input logic [7:0] el);
    chk({tag, "_awaddr"}, (idx < aw_a.size()) ? 64'(aw_a[idx]) : 64'hDEAD, 64'(ea));
    chk({tag, "_awlen"},  (idx < aw_l.size()) ? 64'(aw_l[idx]) : 64'hDEAD, 64'(el));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    // Reset state while rst is held
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_wlast", m_axi_wlast, 1'b0);
    chk("rst_bready", m_axi_bready, 1'b0);
    chk("rst_awaddr", m_axi_awaddr, 32'h0);
    chk("rst_awlen", m_axi_awlen, 8'h0);
    chk("awsize", m_axi_awsize, 3'd2);
    chk("awburst", m_axi_awburst, 2'b01);
    rst = 1'b0;
    tick();

    // 1: 40 words from 0x1000 -> 16/16/8 beat bursts
    clear_logs();
    for (int i = 0; i < 40; i++) src_q.push_back({32'(i), 4'hF});
    start_run(32'h1000, 16'd40);
    wait_done("t1_done", 1);
    repeat (3) tick();
    chk("t1_done_once", done_cnt, 1);
    chk("t1_aw_n", aw_a.size(), 3);
    chk_aw("t1_b0", 0, 32'h1000, 8'd15);
    chk_aw("t1_b1", 1, 32'h1040, 8'd15);
    chk_aw("t1_b2", 2, 32'h1080, 8'd7);
    chk("t1_w_n", w_d.size(), 40);
    for (int i = 0; i < 40; i++) begin
      chk("t1_wdata", (i < w_d.size()) ? 64'(w_d[i]) : 64'hDEAD, 64'({32'(i), 4'hF}));
      chk("t1_wlast", (i < w_l.size()) ? 64'(w_l[i]) : 64'hDEAD, 64'(i == 15 || i == 31 || i == 39));
    end
    chk("t1_b_n", err_hist.size(), 3);
    chk("t1_error", error, 1'b0);
    chk("t1_ready", ready, 1'b1);
    chk("t1_order", order_err, 0);

    // 2: 4 KB split from 0x0FF0
    clear_logs();
    for (int i = 0; i < 8; i++) src_q.push_back({32'(100 + i), 4'hF});
    start_run(32'h0FF0, 16'd8);
    wait_done("t2_done", 1);
    chk("t2_aw_n", aw_a.size(), 2);
    chk_aw("t2_b0", 0, 32'h0FF0, 8'd3);
    chk_aw("t2_b1", 1, 32'h1000, 8'd3);
    chk("t2_w_n", w_d.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("t2_wdata", (i < w_d.size()) ? 64'(w_d[i]) : 64'hDEAD, 64'({32'(100 + i), 4'hF}));

    // 3: SLVERR on second burst, sticky error
    clear_logs();
    err_burst = 1;
    for (int i = 0; i < 40; i++) src_q.push_back({32'(200 + i), 4'hF});
    start_run(32'h2000, 16'd40);
    wait_done("t3_done", 1);
    err_burst = 99;
    chk("t3_aw_n", aw_a.size(), 3);
    chk_aw("t3_b2", 2, 32'h2080, 8'd7);
    chk("t3_b_n", err_hist.size(), 3);
    chk("t3_err_b0", (err_hist.size() > 0) ? 64'(err_hist[0]) : 64'hDEAD, 64'd0);
    chk("t3_err_b1", (err_hist.size() > 1) ? 64'(err_hist[1]) : 64'hDEAD, 64'd1);
    chk("t3_err_b2", (err_hist.size() > 2) ? 64'(err_hist[2]) : 64'hDEAD, 64'd1);
    tick();
    chk("t3_error_sticky", error, 1'b1);

    // 4: slow awready, toggling wready, varied strobes; next run clears error
    clear_logs();
    aw_delay = 5; wr_toggle = 1;
    for (int i = 0; i < 40; i++) src_q.push_back({32'hA500_0000 + 32'(i * 3), 4'(i * 7 + 1)});
    start_run(32'h3000, 16'd40);
    chk("t4_error_cleared", error, 1'b0);
    wait_done("t4_done", 1);
    aw_delay = 0; wr_toggle = 0;
    chk("t4_aw_n", aw_a.size(), 3);
    chk_aw("t4_b0", 0, 32'h3000, 8'd15);
    chk_aw("t4_b2", 2, 32'h3080, 8'd7);
    chk("t4_aw_stable", aw_unstable, 0);
    chk("t4_order", order_err, 0);
    chk("t4_w_n", w_d.size(), 40);
    for (int i = 0; i < 40; i++)
      chk("t4_wdata", (i < w_d.size()) ? 64'(w_d[i]) : 64'hDEAD,
          64'({32'hA500_0000 + 32'(i * 3), 4'(i * 7 + 1)}));

    // 5: zero-length transfer
    clear_logs();
    start_run(32'h4000, 16'd0);
    chk("t5_done_pulse", done, 1'b1);
    chk("t5_ready", ready, 1'b1);
    tick();
    chk("t5_done_low", done, 1'b0);
    chk("t5_ready2", ready, 1'b1);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_no_aw", aw_ever, 1'b0);

    // 6: reset during burst 2 data, then a fresh short transfer
    clear_logs();
    for (int i = 0; i < 40; i++) src_q.push_back({32'(300 + i), 4'hF});
    start_run(32'h5000, 16'd40);
    for (int i = 0; i < 3000 && w_d.size() < 20; i++) tick();
    chk("t6_in_burst2", aw_a.size(), 2);
    rst = 1'b1;
    #1;
    chk("t6_rst_awvalid", m_axi_awvalid, 1'b0);
    chk("t6_rst_wvalid", m_axi_wvalid, 1'b0);
    chk("t6_rst_bready", m_axi_bready, 1'b0);
    chk("t6_rst_ready", ready, 1'b1);
    chk("t6_rst_done", done, 1'b0);
    clear_logs();
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) src_q.push_back({32'hF0 + 32'(i), 4'h3});
    start_run(32'h6000, 16'd4);
    wait_done("t6_done", 1);
    chk("t6_aw_n", aw_a.size(), 1);
    chk_aw("t6_b0", 0, 32'h6000, 8'd3);
    chk("t6_w_n", w_d.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t6_wdata", (i < w_d.size()) ? 64'(w_d[i]) : 64'hDEAD, 64'({32'hF0 + 32'(i), 4'h3}));
      chk("t6_wlast", (i < w_l.size()) ? 64'(w_l[i]) : 64'hDEAD, 64'(i == 3));
    end
    chk("t6_error", error, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iob2axi_wr_burst.md
Name: iob2axi_wr_burst

Overview:
Parametrised native-to-AXI4 write burst engine. Accepts a bounded transfer (start address plus word count) through a control interface. Buffers native-interface write data in an internal FIFO and emits AXI4 INCR write bursts. Each burst is sized by remaining length, a configurable maximum burst and the 4 KB boundary. Adds several things the earlier streaming bridge lacked: a finite transfer length, a configurable FIFO depth and maximum burst, sticky BRESP error capture, and a done pulse.

Parameters:
ADDR_W, 32, byte address width (AXI address width equals ADDR_W)
DATA_W, 32, data width in bits; power of two, at least 8
LEN_W, 16, width of the transfer length in words
AXI_LEN_W, 8, AWLEN width (8 for AXI4)
MAX_BURST, 16, maximum beats per burst; at most 2**AXI_LEN_W and at most FIFO depth
FIFO_ADDR_W, 5, log2 of FIFO depth in words

Ports:
clk  in  1  clock
rst  in  1  reset
run  in  1  start-transfer pulse; sampled only when ready=1
addr  in  ADDR_W  start byte address; low log2(DATA_W/8) bits ignored (treated as 0)
length  in  LEN_W  transfer length in words
ready  out  1  engine idle, accepts run
done  out  1  one-cycle pulse when the transfer completes
error  out  1  sticky; set if any BRESP != OKAY; cleared on the next accepted run
s_valid  in  1  native write request
s_wdata  in  DATA_W  write data
s_wstrb  in  DATA_W/8  byte strobes, forwarded to WSTRB
s_ready  out  1  word accepted this cycle
m_axi_awaddr  out  ADDR_W  burst start address
m_axi_awlen  out  AXI_LEN_W  beats minus 1
m_axi_awsize  out  3  log2(DATA_W/8), constant
m_axi_awburst  out  2  2'b01 (INCR), constant
m_axi_awvalid  out  1  address valid
m_axi_awready  in  1  address ready
m_axi_wdata  out  DATA_W  write data
m_axi_wstrb  out  DATA_W/8  write strobes
m_axi_wlast  out  1  last beat of burst
m_axi_wvalid  out  1  data valid
m_axi_wready  in  1  data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  response valid
m_axi_bready  out  1  response ready

Behaviour:
- Reset rst, asynchronous, active-high; clock clk. All state updates on the rising edge of clk.
- Reset values: ready=1, done=0, error=0, s_ready=0, awvalid=0, wvalid=0, wlast=0, bready=0, awaddr=0, awlen=0; FIFO empty; FSM in IDLE.
- run while ready=0 is ignored.
- Native side:
  - s_ready = busy & ~fifo_full & (accepted_cnt < length_reg), combinational.
  - A word is accepted when s_valid & s_ready.
  - Words offered beyond the transfer length are stalled, never dropped.
- FSM states:
  - IDLE: ready=1. On run, latch addr and length, clear error, go to CALC. If length==0, pulse done on the next cycle and stay in IDLE.
  - CALC: blen = min(remaining, MAX_BURST, words_to_4k), where words_to_4k = (4096 - addr_cur[11:0]) >> log2(DATA_W/8). Wait until fifo_level >= blen, then register awaddr=addr_cur and awlen=blen-1, assert awvalid next cycle, go to ADDR. Compute min() at LEN_W+1 bits to avoid truncation.
  - ADDR: hold awvalid and address until awready; then drop awvalid and go to DATA.
  - DATA: wvalid=1 while beats remain; the FIFO is first-word-fall-through so wdata is valid with wvalid. A beat transfers on wvalid & wready. wlast=1 on beat blen-1. After the last beat, go to RESP.
  - RESP: bready=1. On bvalid: if bresp != 2'b00, set error. Then addr_cur += blen*DATA_W/8 and remaining -= blen. If remaining==0, pulse done and go to IDLE; otherwise go to CALC.
- Only one burst is outstanding at a time. W beats never start before the AW handshake.
- Data order, wstrb and beat count are preserved exactly; no beat is issued without FIFO data.
- Address wraps modulo 2**ADDR_W; bursts never cross a 4 KB boundary.
- Simultaneous FIFO write and read in the same cycle are supported; the level is unchanged.
- Reset mid-transfer aborts it: all outputs return to reset values and FIFO contents are discarded.

Decomposition:
- Shared package/header holds the AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00, AXI4 LEN width 8, and the 4 KB boundary constant 12. FSM state encodings are local.
- One sub-module: the existing iob_fifo_sync, sized DATA_W+DATA_W/8 wide and 2**FIFO_ADDR_W deep, with a level output. First-word-fall-through behaviour is provided by a small output register stage inside this block.

Test Plan:
1. DATA_W=32, MAX_BURST=16: run with addr=0x1000, length=40, data streamed 0..39 -> three bursts at awaddr 0x1000/0x1040/0x1080 with awlen 15/15/7; wlast on beats 16, 32, 40; done pulses once after the third B; error=0.
2. addr=0x0FF0, length=8 -> two bursts: 0x0FF0 with awlen=3, then 0x1000 with awlen=3; no burst spans 0x1000.
3. length=40 with bresp=2'b10 on the second burst -> error rises after that B and stays 1; the third burst is still issued; done pulses; the next run clears error.
4. awready delayed 5 cycles, wready toggling 1010 -> wdata sequence and wstrb identical to input; awvalid held stable until accepted; exactly 40 W beats.
5. length=0 -> done pulses 1 cycle after run; awvalid never asserted; ready stays 1.
6. rst asserted during DATA of burst 2 -> next cycle awvalid=wvalid=bready=0, ready=1, done=0; a new run with length=4 completes normally with fresh data only.
